booth_mult_r4: RTL and testbench

Iterative radix-4 Booth multiplier, the parametrised successor of the team's radix-2 sequential Booth multiplier. It accepts a generic operand width, runs signed or unsigned per operation, and retires two multiplier bits per cycle. It uses a start/busy/done handshake with a one-cycle done pulse, and it sits beside the ALU datapath as the multi-cycle MUL unit.

---
 rtl/booth_pkg.sv | 13 +
 rtl/booth_r4_encoder.sv | 28 ++
 rtl/booth_mult_r4.sv | 99 +++++++++
 tb/tb_booth_mult_r4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {ZERO, PM, P2M, NM, N2M} digit_t;

    // Iterations needed to retire a WIDTH+2 bit extended multiplier two bits at a time.
    function automatic int N(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps {q[i+1], q[i], q[i-1]} to a magnitude select and a negate flag.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] i_bits,
    output logic       o_one,
    output logic       o_two,
    output logic       o_neg
);

    digit_t w_digit;

    always_comb begin
        w_digit = ZERO;
        case (i_bits)
            3'b001, 3'b010: w_digit = PM;
            3'b011:         w_digit = P2M;
            3'b100:         w_digit = N2M;
            3'b101, 3'b110: w_digit = NM;
            default:        w_digit = ZERO;
        endcase
    end

    assign o_one = (w_digit == PM)  || (w_digit == NM);
    assign o_two = (w_digit == P2M) || (w_digit == N2M);
    assign o_neg = (w_digit == NM)  || (w_digit == N2M);

endmodule

// File: rtl/booth_mult_r4.sv
// Iterative radix-4 Booth multiplier, signed or unsigned per operation, two multiplier bits per cycle.
module booth_mult_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int NIT = N(WIDTH);
    localparam int CW  = $clog2(NIT + 1);
    localparam int AW  = WIDTH + 4;
    localparam int QW  = WIDTH + 2;

    state_t                r_state, w_next;
    logic signed [AW-1:0]  r_ac;
    logic [QW-1:0]         r_qr;
    logic [QW-1:0]         r_m;
    logic                  r_qn1;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_result;

    logic                  w_one, w_two, w_neg;
    logic signed [AW-1:0]  w_m_aw, w_mag, w_addend, w_sum;

    booth_r4_encoder u_enc (
        .i_bits ({r_qr[1:0], r_qn1}),
        .o_one  (w_one),
        .o_two  (w_two),
        .o_neg  (w_neg)
    );

    // r_m is already extended, so its MSB is the correct fill for either mode.
    assign w_m_aw   = {{2{r_m[QW-1]}}, r_m};
    assign w_mag    = w_two ? (w_m_aw <<< 1) : (w_one ? w_m_aw : '0);
    assign w_addend = w_neg ? -w_mag : w_mag;
    assign w_sum    = r_ac + w_addend;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ac     <= '0;
            r_qr     <= '0;
            r_m      <= '0;
            r_qn1    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_ac  <= '0;
                    r_qn1 <= 1'b0;
                    r_cnt <= CW'(NIT);
                    r_m   <= signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
                    r_qr  <= signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
                end
                RUN: begin
                    // Arithmetic shift right by 2 of {sum, QR, Qn1}.
                    r_ac  <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
                    r_qr  <= {w_sum[1:0], r_qr[QW-1:2]};
                    r_qn1 <= r_qr[1];
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: begin
                    r_result <= {r_ac[WIDTH-3:0], r_qr};
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH=32 and WIDTH=8 against an arithmetic reference.
module tb_booth_mult_r4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, sm32, busy32, done32;
    logic [31:0] m32, q32;
    logic [63:0] res32;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] res8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mult_r4 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .M(m32), .Q(q32),
        .signed_mode(sm32), .busy(busy32), .done(done32), .result(res32)
    );

    booth_mult_r4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .M(m8), .Q(q8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .result(res8)
    );

    function automatic logic [63:0] ref32(input logic [31:0] m, input logic [31:0] q, input logic sm);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sm) begin
            sa = longint'($signed(m));
            sb = longint'($signed(q));
            return 64'(sa * sb);
        end
        ua = 64'(m);
        ub = 64'(q);
        return ua * ub;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q, input logic sm);
        int sa, sb;
        if (sm) begin
            sa = int'($signed(m));
            sb = int'($signed(q));
        end else begin
            sa = int'(m);
            sb = int'(q);
        end
        return 16'(sa * sb);
    endfunction

    // Starts one WIDTH=32 operation (caller is 1 time unit after an edge, DUT idle) and checks it.
    task automatic op32(input logic [31:0] m, input logic [31:0] q, input logic sm, input string name);
        logic [63:0] exp;
        int          lat;
        exp = ref32(m, q, sm);
        m32 = m; q32 = q; sm32 = sm; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; m32 = $urandom; q32 = $urandom; sm32 = ~sm;
        checks++;
        if (busy32 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, busy32);
        end
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) lat = i;
        end
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL %s latency: got %0d want 18", name, lat);
        end
        checks++;
        if (res32 !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, res32, exp);
        end
    endtask

    task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic sm);
        logic [15:0] exp;
        int          lat;
        exp = ref8(m, q, sm);
        m8 = m; q8 = q; sm8 = sm; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) lat = i;
        end
        checks++;
        if (lat != 6 || res8 !== exp) begin
            errors++;
            $display("FAIL w8 m=%h q=%h s=%b: got %h lat %0d want %h lat 6", m, q, sm, res8, lat, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start32 = 1'b1; start8 = 1'b1;
        m32 = 32'd9; q32 = 32'd9; sm32 = 1'b0; m8 = 8'd3; q8 = 8'd3; sm8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (busy32 !== 1'b0)  begin errors++; $display("FAIL reset busy32: got %b want 0", busy32); end
        if (done32 !== 1'b0)  begin errors++; $display("FAIL reset done32: got %b want 0", done32); end
        if (res32 !== 64'd0)  begin errors++; $display("FAIL reset result32: got %h want 0", res32); end
        if (busy8 !== 1'b0)   begin errors++; $display("FAIL reset busy8: got %b want 0", busy8); end
        if (done8 !== 1'b0)   begin errors++; $display("FAIL reset done8: got %b want 0", done8); end
        if (res8 !== 16'd0)   begin errors++; $display("FAIL reset result8: got %h want 0", res8); end
        start32 = 1'b0; start8 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, "smin_sq");
        op32(32'h8000_0000, 32'h0000_0001, 1'b1, "smin_x1");
        op32(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, "neg1_x7_s");
        op32(32'hFFFF_FFFF, 32'h0000_0007, 1'b0, "neg1_x7_u");
        op32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "smax_smin");
        op32(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, "zero_m");
        checks++;
        if (64'hFFFF_FFFF_FFFF_FFF9 !== ref32(32'hFFFF_FFFF, 32'h7, 1'b1) || res32 !== 64'd0) begin
            errors++;
            $display("FAIL zero_m held: got %h want 0", res32);
        end
    endtask

    task automatic test_random32();
        for (int i = 0; i < 150; i++)
            op32($urandom, $urandom, 1'($urandom_range(0, 1)), "rand32");
    endtask

    task automatic test_restart_ignored();
        logic [63:0] exp;
        int          ndone, first;
        exp = ref32(32'h0000_1234, 32'h0000_0100, 1'b0);
        m32 = 32'h0000_1234; q32 = 32'h0000_0100; sm32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        m32 = 32'h0000_0003; q32 = 32'h0000_0003; sm32 = 1'b1;
        ndone = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            start32 = (i == 5);
            @(posedge clk); #1;
            if (done32 === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        start32 = 1'b0;
        checks += 3;
        if (ndone != 1)   begin errors++; $display("FAIL restart done_count: got %0d want 1", ndone); end
        if (first != 18)  begin errors++; $display("FAIL restart done_cycle: got %0d want 18", first); end
        if (res32 !== exp) begin errors++; $display("FAIL restart result: got %h want %h", res32, exp); end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        int p0, p1, p2;
        m32 = 32'hFFFF_FFFF; q32 = 32'h0000_0007; sm32 = 1'b1; start32 = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) begin
                pos.push_back(i);
                checks++;
                if (res32 !== 64'hFFFF_FFFF_FFFF_FFF9) begin
                    errors++;
                    $display("FAIL b2b result: got %h want fffffffffffffff9", res32);
                end
            end
        end
        start32 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        p0 = (pos.size() > 0) ? pos[0] : -1;
        p1 = (pos.size() > 1) ? pos[1] : -1;
        p2 = (pos.size() > 2) ? pos[2] : -1;
        checks += 4;
        if (pos.size() != 3) begin errors++; $display("FAIL b2b count: got %0d want 3", pos.size()); end
        if (p0 != 18) begin errors++; $display("FAIL b2b done0: got %0d want 18", p0); end
        if (p1 != 37) begin errors++; $display("FAIL b2b done1: got %0d want 37", p1); end
        if (p2 != 56) begin errors++; $display("FAIL b2b done2: got %0d want 56", p2); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        m32 = 32'h0001_2345; q32 = 32'h0000_6789; sm32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 3;
        if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy32); end
        if (done32 !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b want 0", done32); end
        if (res32 !== 64'd0) begin errors++; $display("FAIL rst_mid result: got %h want 0", res32); end
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL rst_mid stray_done: got %0d want 0", ndone); end
        op32(32'd3, 32'd5, 1'b0, "rst_then_3x5");
    endtask

    task automatic test_w8();
        logic [7:0] corner [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 6; b++) begin
                op8(corner[a], corner[b], 1'b0);
                op8(corner[a], corner[b], 1'b1);
            end
        for (int i = 0; i < 2500; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
        m32 = '0; q32 = '0; sm32 = 1'b0; m8 = '0; q8 = '0; sm8 = 1'b0;
        test_reset();
        test_vectors();
        test_random32();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
